// File: rtl/fpu_exce_status.sv
// Sticky FPU exception status: per-class flags, maskable IRQ, first-fault capture, host port.
// Optional saturating event counter at address 5 when FPU_EXCE_CNT_EN is defined.
module fpu_exce_status #(
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    input  logic [1:0] fp_operation_i,
    input  logic [7:0] op_a_i,
    input  logic [7:0] op_b_i,
    input  logic       op_is_exception_i,
    input  logic [2:0] fp_exce_i,
    input  logic [2:0] reg_addr_i,
    input  logic       reg_rd_i,
    input  logic       reg_wr_i,
    input  logic [7:0] reg_wdata_i,
    output logic [7:0] reg_rdata_o,
    output logic       irq_o
);

    // Exception codes as emitted by the checker.
    localparam logic [2:0] ExceNone    = 3'd0;
    localparam logic [2:0] ExceQnan    = 3'd1;
    localparam logic [2:0] ExceSnan    = 3'd2;
    localparam logic [2:0] ExceInf     = 3'd3;
    localparam logic [2:0] ExceZeroDiv = 3'd4;

    localparam logic [2:0] AddrStatus = 3'd0;
    localparam logic [2:0] AddrMask   = 3'd1;
    localparam logic [2:0] AddrCapOp  = 3'd2;
    localparam logic [2:0] AddrCapA   = 3'd3;
    localparam logic [2:0] AddrCapB   = 3'd4;
    localparam logic [2:0] AddrEvtCnt = 3'd5;

    typedef enum logic [0:0] {StArmed, StHeld} cap_state_e;

    cap_state_e cap_state_q;
    logic [3:0] flags_q, flags_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] cap_op_q;
    logic [2:0] cap_code_q;
    logic [7:0] cap_a_q, cap_b_q;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] cnt_rd;
    logic [3:0] evt_bits;
    logic       evt;
    logic       wr_status, wr_mask, wr_cnt;
    logic       cap_valid;
    logic [2:0] unused_wdata;

    assign unused_wdata = reg_wdata_i[7:5];

    always_comb begin
        evt_bits = 4'b0000;
        if (in_valid_i && op_is_exception_i) begin
            unique case (fp_exce_i)
                ExceQnan:    evt_bits = 4'b0001;
                ExceSnan:    evt_bits = 4'b0010;
                ExceInf:     evt_bits = 4'b0100;
                ExceZeroDiv: evt_bits = 4'b1000;
                default:     evt_bits = 4'b0000;
            endcase
        end
    end

    assign evt       = |evt_bits;
    assign wr_status = reg_wr_i && (reg_addr_i == AddrStatus);
    assign wr_mask   = reg_wr_i && (reg_addr_i == AddrMask);
    assign wr_cnt    = reg_wr_i && (reg_addr_i == AddrEvtCnt);
    assign cap_valid = (cap_state_q == StHeld);

    // Set beats W1C when both hit the same flag.
    always_comb begin
        flags_d = flags_q;
        if (wr_status) begin
            flags_d = flags_d & ~reg_wdata_i[3:0];
        end
        flags_d = flags_d | evt_bits;
    end

    always_comb begin
        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = reg_wdata_i[3:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= 4'b0000;
            mask_q  <= 4'b0000;
        end else begin
            flags_q <= flags_d;
            mask_q  <= mask_d;
        end
    end

    // A release and a new event in the same cycle re-captures and stays held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_state_q <= StArmed;
            cap_op_q    <= 2'b00;
            cap_code_q  <= ExceNone;
            cap_a_q     <= 8'h00;
            cap_b_q     <= 8'h00;
        end else begin
            if (evt && (cap_state_q == StArmed || (wr_status && reg_wdata_i[4]))) begin
                cap_state_q <= StHeld;
                cap_op_q    <= fp_operation_i;
                cap_code_q  <= fp_exce_i;
                cap_a_q     <= op_a_i;
                cap_b_q     <= op_b_i;
            end else if (wr_status && reg_wdata_i[4]) begin
                cap_state_q <= StArmed;
            end
        end
    end

`ifdef FPU_EXCE_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_cnt) begin
            cnt_d = evt ? CNT_W'(1) : '0;
        end else if (evt && cnt_q != CntMax) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (CNT_W >= 8) begin : g_cnt_wide
        assign cnt_rd = cnt_q[7:0];
    end else begin : g_cnt_narrow
        assign cnt_rd = {{(8 - CNT_W){1'b0}}, cnt_q};
    end
`else
    logic unused_wr_cnt;

    assign unused_wr_cnt = wr_cnt;
    assign cnt_rd        = 8'h00;
`endif

    // Reads sample state before any same-cycle write lands.
    always_comb begin
        rdata_d = rdata_q;
        if (reg_rd_i) begin
            unique case (reg_addr_i)
                AddrStatus: rdata_d = {3'b000, cap_valid, flags_q};
                AddrMask:   rdata_d = {4'h0, mask_q};
                AddrCapOp:  rdata_d = {3'b000, cap_code_q, cap_op_q};
                AddrCapA:   rdata_d = cap_a_q;
                AddrCapB:   rdata_d = cap_b_q;
                AddrEvtCnt: rdata_d = cnt_rd;
                default:    rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign reg_rdata_o = rdata_q;
    assign irq_o       = |(flags_q & mask_q);

endmodule

// File: tb/tb_fpu_exce_status.sv
// Directed bench for fpu_exce_status; exercises the counter path only when FPU_EXCE_CNT_EN is set.
module tb_fpu_exce_status;

    localparam logic [2:0] ENone = 3'd0;
    localparam logic [2:0] EQnan = 3'd1;
    localparam logic [2:0] ESnan = 3'd2;
    localparam logic [2:0] EInf  = 3'd3;
    localparam logic [2:0] EZdiv = 3'd4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       in_valid_i = 1'b0;
    logic [1:0] fp_operation_i = 2'b00;
    logic [7:0] op_a_i = 8'h00;
    logic [7:0] op_b_i = 8'h00;
    logic       op_is_exception_i = 1'b0;
    logic [2:0] fp_exce_i = 3'd0;
    logic [2:0] reg_addr_i = 3'd0;
    logic       reg_rd_i = 1'b0;
    logic       reg_wr_i = 1'b0;
    logic [7:0] reg_wdata_i = 8'h00;
    logic [7:0] reg_rdata_o;
    logic       irq_o;

    int checks = 0;
    int errors = 0;

    fpu_exce_status dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .in_valid_i       (in_valid_i),
        .fp_operation_i   (fp_operation_i),
        .op_a_i           (op_a_i),
        .op_b_i           (op_b_i),
        .op_is_exception_i(op_is_exception_i),
        .fp_exce_i        (fp_exce_i),
        .reg_addr_i       (reg_addr_i),
        .reg_rd_i         (reg_rd_i),
        .reg_wr_i         (reg_wr_i),
        .reg_wdata_i      (reg_wdata_i),
        .reg_rdata_o      (reg_rdata_o),
        .irq_o            (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_evt(input logic v, input logic ie, input logic [2:0] code,
                           input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid_i        = v;
        op_is_exception_i = ie;
        fp_exce_i         = code;
        fp_operation_i    = op;
        op_a_i            = a;
        op_b_i            = b;
    endtask

    task automatic clr_evt();
        set_evt(1'b0, 1'b0, ENone, 2'b00, 8'h00, 8'h00);
    endtask

    task automatic evt(input logic [2:0] code, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b);
        set_evt(1'b1, 1'b1, code, op, a, b);
        step();
        clr_evt();
    endtask

    task automatic rd(input logic [2:0] addr, output logic [7:0] data);
        reg_addr_i = addr;
        reg_rd_i   = 1'b1;
        step();
        reg_rd_i = 1'b0;
        data     = reg_rdata_o;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        reg_addr_i  = addr;
        reg_wdata_i = data;
        reg_wr_i    = 1'b1;
        step();
        reg_wr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        checks++;
        if (irq_o !== 1'b0) begin
            $display("FAIL reset_irq: got %b want 0", irq_o);
            errors++;
        end
        wr(3'd1, 8'h0F);
        evt(EInf, 2'b10, 8'h11, 8'h22);
        checks++;
        if (irq_o !== 1'b1) begin
            $display("FAIL pre_reset_irq: got %b want 1", irq_o);
            errors++;
        end
        rd(3'd3, d);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (irq_o !== 1'b0 || reg_rdata_o !== 8'h00) begin
            $display("FAIL async_reset: irq %b rdata %h want 0 00", irq_o, reg_rdata_o);
            errors++;
        end
        step();
        rst_ni = 1'b1;
        step();
        for (int a = 0; a < 8; a++) begin
            rd(a[2:0], d);
            checks++;
            if (d !== 8'h00) begin
                $display("FAIL reset_reg%0d: got %h want 00", a, d);
                errors++;
            end
        end
        evt(ESnan, 2'b01, 8'h77, 8'h66);
        rd(3'd3, d);
        checks++;
        if (d !== 8'h77) begin
            $display("FAIL reset_armed_cap: got %h want 77", d);
            errors++;
        end
    endtask

    task automatic test_capture();
        logic [7:0] d;
        do_reset();
        evt(EZdiv, 2'b11, 8'h3C, 8'h00);
        rd(3'd0, d);
        checks++;
        if (d !== 8'h18) begin
            $display("FAIL cap_status: got %h want 18", d);
            errors++;
        end
        rd(3'd2, d);
        checks++;
        if (d !== 8'h13) begin
            $display("FAIL cap_op: got %h want 13", d);
            errors++;
        end
        rd(3'd3, d);
        checks++;
        if (d !== 8'h3C) begin
            $display("FAIL cap_a: got %h want 3c", d);
            errors++;
        end
        rd(3'd4, d);
        checks++;
        if (d !== 8'h00) begin
            $display("FAIL cap_b: got %h want 00", d);
            errors++;
        end
        evt(EQnan, 2'b00, 8'h99, 8'h88);
        rd(3'd0, d);
        checks++;
        if (d !== 8'h19) begin
            $display("FAIL cap_status2: got %h want 19", d);
            errors++;
        end
        rd(3'd2, d);
        checks++;
        if (d !== 8'h13) begin
            $display("FAIL cap_op_held: got %h want 13", d);
            errors++;
        end
        rd(3'd3, d);
        checks++;
        if (d !== 8'h3C) begin
            $display("FAIL cap_a_held: got %h want 3c", d);
            errors++;
        end
    endtask

    task automatic test_irq();
        do_reset();
        wr(3'd1, 8'h08);
        checks++;
        if (irq_o !== 1'b0) begin
            $display("FAIL irq_idle: got %b want 0", irq_o);
            errors++;
        end
        evt(EZdiv, 2'b11, 8'h01, 8'h00);
        checks++;
        if (irq_o !== 1'b1) begin
            $display("FAIL irq_rise: got %b want 1", irq_o);
            errors++;
        end
        wr(3'd0, 8'h08);
        checks++;
        if (irq_o !== 1'b0) begin
            $display("FAIL irq_clear: got %b want 0", irq_o);
            errors++;
        end
        wr(3'd1, 8'h00);
        evt(EZdiv, 2'b11, 8'h01, 8'h00);
        evt(EQnan, 2'b00, 8'h01, 8'h02);
        checks++;
        if (irq_o !== 1'b0) begin
            $display("FAIL irq_masked: got %b want 0", irq_o);
            errors++;
        end
    endtask

    task automatic test_w1c_race();
        logic [7:0] d;
        do_reset();
        evt(EZdiv, 2'b11, 8'h3C, 8'h00);
        reg_addr_i  = 3'd0;
        reg_wdata_i = 8'h11;
        reg_wr_i    = 1'b1;
        set_evt(1'b1, 1'b1, EQnan, 2'b01, 8'h55, 8'hAA);
        step();
        reg_wr_i = 1'b0;
        clr_evt();
        rd(3'd0, d);
        checks++;
        if (d !== 8'h19) begin
            $display("FAIL race_status: got %h want 19", d);
            errors++;
        end
        rd(3'd2, d);
        checks++;
        if (d !== 8'h05) begin
            $display("FAIL race_cap_op: got %h want 05", d);
            errors++;
        end
        rd(3'd4, d);
        checks++;
        if (d !== 8'hAA) begin
            $display("FAIL race_cap_b: got %h want aa", d);
            errors++;
        end
        wr(3'd0, 8'h10);
        rd(3'd0, d);
        checks++;
        if (d !== 8'h09) begin
            $display("FAIL release_status: got %h want 09", d);
            errors++;
        end
    endtask

    task automatic test_ignored();
        logic [7:0] d;
        do_reset();
        set_evt(1'b1, 1'b1, ENone, 2'b11, 8'h12, 8'h34);
        step();
        set_evt(1'b0, 1'b1, EQnan, 2'b11, 8'h12, 8'h34);
        step();
        set_evt(1'b1, 1'b0, EZdiv, 2'b11, 8'h12, 8'h34);
        step();
        set_evt(1'b1, 1'b1, 3'd6, 2'b11, 8'h12, 8'h34);
        step();
        clr_evt();
        rd(3'd0, d);
        checks++;
        if (d !== 8'h00) begin
            $display("FAIL ignore_status: got %h want 00", d);
            errors++;
        end
        rd(3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            $display("FAIL ignore_cap_a: got %h want 00", d);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        do_reset();
        set_evt(1'b1, 1'b1, EQnan, 2'b00, 8'hA1, 8'hB1);
        step();
        set_evt(1'b1, 1'b1, ESnan, 2'b01, 8'hA2, 8'hB2);
        step();
        set_evt(1'b1, 1'b1, EInf, 2'b10, 8'hA3, 8'hB3);
        step();
        clr_evt();
        rd(3'd0, d);
        checks++;
        if (d !== 8'h17) begin
            $display("FAIL b2b_status: got %h want 17", d);
            errors++;
        end
        rd(3'd3, d);
        checks++;
        if (d !== 8'hA1) begin
            $display("FAIL b2b_cap_a: got %h want a1", d);
            errors++;
        end
    endtask

    task automatic test_rd_wr_same();
        logic [7:0] d;
        do_reset();
        wr(3'd1, 8'hFF);
        reg_addr_i  = 3'd1;
        reg_wdata_i = 8'h03;
        reg_wr_i    = 1'b1;
        reg_rd_i    = 1'b1;
        step();
        reg_wr_i = 1'b0;
        reg_rd_i = 1'b0;
        checks++;
        if (reg_rdata_o !== 8'h0F) begin
            $display("FAIL rdwr_old: got %h want 0f", reg_rdata_o);
            errors++;
        end
        rd(3'd1, d);
        checks++;
        if (d !== 8'h03) begin
            $display("FAIL rdwr_new: got %h want 03", d);
            errors++;
        end
    endtask

    task automatic test_counter();
        logic [7:0] d;
        do_reset();
`ifdef FPU_EXCE_CNT_EN
        set_evt(1'b1, 1'b1, EInf, 2'b10, 8'h01, 8'h02);
        for (int i = 0; i < 300; i++) begin
            step();
        end
        clr_evt();
        rd(3'd5, d);
        checks++;
        if (d !== 8'hFF) begin
            $display("FAIL cnt_sat: got %h want ff", d);
            errors++;
        end
        wr(3'd5, 8'h5A);
        rd(3'd5, d);
        checks++;
        if (d !== 8'h00) begin
            $display("FAIL cnt_clear: got %h want 00", d);
            errors++;
        end
        evt(EQnan, 2'b00, 8'h00, 8'h00);
        evt(EQnan, 2'b00, 8'h00, 8'h00);
        reg_addr_i  = 3'd5;
        reg_wdata_i = 8'h00;
        reg_wr_i    = 1'b1;
        set_evt(1'b1, 1'b1, ESnan, 2'b00, 8'h00, 8'h00);
        step();
        reg_wr_i = 1'b0;
        clr_evt();
        rd(3'd5, d);
        checks++;
        if (d !== 8'h01) begin
            $display("FAIL cnt_clear_evt: got %h want 01", d);
            errors++;
        end
`else
        evt(EInf, 2'b10, 8'h01, 8'h02);
        evt(EInf, 2'b10, 8'h01, 8'h02);
        wr(3'd5, 8'h7E);
        rd(3'd5, d);
        checks++;
        if (d !== 8'h00) begin
            $display("FAIL cnt_absent: got %h want 00", d);
            errors++;
        end
`endif
    endtask

    initial begin
        clr_evt();
        test_reset();
        test_capture();
        test_irq();
        test_w1c_race();
        test_ignored();
        test_back_to_back();
        test_rd_wr_same();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
